disp_scan: RTL and testbench

Time-multiplexed scanner for a multi-digit common-anode seven-segment display. Holds a frame of hex digits and cycles through them one at a time at a fixed refresh rate. Presents the selected nibble and enable to the downstream `seven_seg` decoder (`in`, `enable`) and drives the active-low digit anodes. Updates are double-buffered so a new value never tears mid-frame, and leading zeros can be blanked.

---
 rtl/disp_pkg.sv | 23 ++
 rtl/tick_gen.sv | 28 ++
 rtl/disp_scan.sv | 109 ++++++++++
 tb/tb_disp_scan.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types, defaults and the leading-zero blanking rule for the display scanner.
// Values are passed zero-extended to 32 bits so one function serves every digit count.
package disp_pkg;

    localparam int DEF_NUM_DIGITS  = 4;
    localparam int DEF_REFRESH_DIV = 50000;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        ST_RST,
        ST_SCAN
    } scan_state_t;

    // A digit is a leading zero when it and every more significant nibble are zero.
    // Digit 0 is never blanked, so an all-zero value still shows "0".
    function automatic logic lz_blank(input logic [31:0] value, input logic [2:0] idx);
        logic [31:0] upper;
        upper = value >> {idx, 2'b00};
        return (idx != 3'd0) && (upper == 32'd0);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for one cycle out of every DIV.
// Kept generic so the same block can time refresh and debounce intervals.
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/disp_scan.sv
// Seven-segment digit scanner with double-buffered frame updates and leading-zero blanking.
// All outputs are registered and change together on the digit step edge.
module disp_scan
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [3:0]              digit_out,
    output logic                    seg_enable,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pend_valid;
    nibble_t                 r_digit;
    logic                    r_seg_en;
    logic [NUM_DIGITS-1:0]   r_anode_n;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_step;
    logic                    w_wrap;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] w_shadow_nxt;
    logic [31:0]             w_frame32;
    logic [31:0]             w_frame_sh;
    nibble_t                 w_digit_nxt;
    logic                    w_blank_nxt;
    logic [NUM_DIGITS-1:0]   w_anode_nxt;

    tick_gen #(
        .DIV(REFRESH_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (w_tick)
    );

    // Outputs are computed from the post-step index and shadow so that the
    // first digit of a frame already reflects a pending buffer transfer.
    always_comb begin
        w_step       = w_tick && (r_state == ST_SCAN);
        w_wrap       = w_step && (r_idx == LAST_IDX);
        w_idx_nxt    = w_wrap ? '0 : r_idx + 1'b1;
        w_shadow_nxt = (w_wrap && r_pend_valid) ? r_pending : r_shadow;
        w_frame32    = '0;
        w_frame32[4*NUM_DIGITS-1:0] = w_shadow_nxt;
        w_frame_sh   = w_frame32 >> {3'(w_idx_nxt), 2'b00};
        w_digit_nxt  = w_frame_sh[3:0];
        w_blank_nxt  = blank_lz && lz_blank(w_frame32, 3'(w_idx_nxt));
        w_anode_nxt  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_anode_nxt[i] = (w_idx_nxt != IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RST;
            r_idx        <= LAST_IDX;
            r_shadow     <= '0;
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            r_digit      <= '0;
            r_seg_en     <= 1'b0;
            r_anode_n    <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= ST_SCAN;
            r_frame_done <= w_wrap;

            // A load coinciding with the wrap lands in pending only; the
            // transfer above has already consumed the previous pending value.
            if (load) begin
                r_pending    <= value;
                r_pend_valid <= 1'b1;
            end else if (w_wrap) begin
                r_pend_valid <= 1'b0;
            end

            if (w_step) begin
                r_idx     <= w_idx_nxt;
                r_shadow  <= w_shadow_nxt;
                r_digit   <= w_digit_nxt;
                r_seg_en  <= !w_blank_nxt;
                r_anode_n <= w_anode_nxt;
            end
        end
    end

    assign digit_out  = r_digit;
    assign seg_enable = r_seg_en;
    assign anode_n    = r_anode_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan (4 digits, 4-cycle slots) with a scoreboard of per-slot outputs.
module tb_disp_scan;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] dig;
        logic       en;
        logic       fd;
    } slot_t;

    localparam slot_t RST_EXP = '{an: 4'b1111, dig: 4'h0, en: 1'b0, fd: 1'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  digit_out;
    logic        seg_enable;
    logic [3:0]  anode_n;
    logic        frame_done;

    slot_t sb[$];
    slot_t cur = RST_EXP;
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    disp_scan #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .load      (load),
        .blank_lz  (blank_lz),
        .digit_out (digit_out),
        .seg_enable(seg_enable),
        .anode_n   (anode_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input slot_t obs, input slot_t expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d: observed an=%b dig=%h en=%b fd=%b, expected an=%b dig=%h en=%b fd=%b",
                   tag, cyc, obs.an, obs.dig, obs.en, obs.fd, expv.an, expv.dig, expv.en, expv.fd);
        end
    endtask

    // Expected slots for digits 0..ndig-1 of one frame showing v.
    task automatic push_frame(input logic [15:0] v, input logic blz, input int ndig);
        slot_t e;
        logic [15:0] upper;
        for (int i = 0; i < ndig; i++) begin
            upper = v >> (4 * i);
            e.an  = 4'b1111 & ~(4'b0001 << i);
            e.dig = upper[3:0];
            e.en  = !(blz && (i > 0) && (upper == 16'h0000));
            e.fd  = (i == 0);
            sb.push_back(e);
        end
    endtask

    // One clock; cycles are numbered from the first edge after reset releases,
    // so digit steps fall on every fourth cycle starting at 4.
    task automatic tick_cyc();
        logic  rs;
        slot_t obs;
        slot_t hold;
        rs = reset;
        @(posedge clk);
        #1;
        obs = '{an: anode_n, dig: digit_out, en: seg_enable, fd: frame_done};
        if (rs) begin
            cyc = 0;
            cur = RST_EXP;
            check("reset_vals", obs, RST_EXP);
        end else begin
            cyc++;
            if (cyc < 4) begin
                check("pre_tick", obs, RST_EXP);
            end else if (cyc % 4 == 0) begin
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_bad++;
                    $error("FAIL sb_underflow cyc=%0d: observed queue size %0d, expected nonzero", cyc, sb.size());
                end
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    check("digit_step", obs, cur);
                end
            end else begin
                hold    = cur;
                hold.fd = 1'b0;
                check("digit_hold", obs, hold);
            end
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick_cyc();
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick_cyc();
        load  = 1'b0;
    endtask

    initial begin
        // Reset for three edges, then release.
        repeat (3) tick_cyc();
        reset = 1'b0;
        push_frame(16'h0000, 1'b0, 4);

        // Scan order: 1234 shown for two frames.
        run_to(6);
        do_load(16'h1234);
        push_frame(16'h1234, 1'b0, 4);
        push_frame(16'h1234, 1'b0, 4);

        // Double buffering: load while digit 2 of frame 2 is active.
        run_to(44);
        do_load(16'hABCD);
        push_frame(16'hABCD, 1'b0, 4);

        // Last of several loads in a frame wins.
        run_to(54);
        do_load(16'h1111);
        run_to(59);
        do_load(16'h2222);
        push_frame(16'h2222, 1'b0, 4);

        // Load on the wrap edge waits a frame; the wrap uses the older pending.
        run_to(72);
        do_load(16'h3333);
        push_frame(16'h3333, 1'b0, 4);
        run_to(83);
        do_load(16'h5678);
        push_frame(16'h5678, 1'b0, 4);

        // Leading-zero blanking.
        run_to(112);
        blank_lz = 1'b1;
        do_load(16'h0050);
        push_frame(16'h0050, 1'b1, 4);
        run_to(120);
        do_load(16'h0000);
        push_frame(16'h0000, 1'b1, 4);
        run_to(136);
        do_load(16'h0050);
        run_to(144);
        blank_lz = 1'b0;
        push_frame(16'h0050, 1'b0, 3);

        // Reset while digit 2 is active, with a load still pending.
        run_to(150);
        do_load(16'h9999);
        run_to(156);
        reset = 1'b1;
        repeat (2) tick_cyc();
        reset = 1'b0;
        push_frame(16'h0000, 1'b0, 4);
        push_frame(16'h0000, 1'b0, 4);
        run_to(35);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL sb_leftover: observed %0d entries, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
